// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, a req/ack fetch to instruction memory,
// and the IF/ID register with a one-entry skid buffer for stalled acks.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_ack_i,
  input  logic [31:0] rom_data_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic        stallreq_o
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic        redirect_pending, pending_next;
  logic [31:0] redirect_target, target_next;
  logic [31:0] skid_pc, skid_inst;
  logic        ack_fire;
  logic        branch_take;
  logic        redirect_valid;
  logic [31:0] redirect_addr;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  assign rom_req_o      = (state == FETCH) && !rst;
  assign rom_addr_o     = word_align(pc);
  assign stallreq_o     = rom_req_o & ~rom_ack_i;
  assign ack_fire       = rom_req_o & rom_ack_i;
  assign branch_take    = branch_flag_i & ~stall_i;
  // A branch seen this edge takes priority over (and replaces) a latched one.
  assign redirect_valid = branch_take | redirect_pending;
  assign redirect_addr  = branch_take ? word_align(branch_target_address_i) : redirect_target;

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = redirect_pending;
    target_next  = redirect_target;
    case (state)
      FETCH: begin
        if (ack_fire) begin
          pc_next      = redirect_valid ? redirect_addr : pc + 32'd4;
          pending_next = 1'b0;
          if (stall_i) state_next = HOLD;
        end else if (branch_take) begin
          // The in-flight fetch becomes the delay slot; the target waits for it.
          pending_next = 1'b1;
          target_next  = word_align(branch_target_address_i);
        end
      end
      HOLD: begin
        if (!stall_i) begin
          state_next = FETCH;
          // No request is outstanding here, so a redirect can update pc directly.
          if (redirect_valid) begin
            pc_next      = redirect_addr;
            pending_next = 1'b0;
          end
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= FETCH;
      pc               <= word_align(RESET_PC);
      redirect_pending <= 1'b0;
    end else begin
      state            <= state_next;
      pc               <= pc_next;
      redirect_pending <= pending_next;
    end
  end

  always_ff @(posedge clk) begin
    redirect_target <= target_next;
    if (ack_fire && stall_i) begin
      skid_pc   <= pc;
      skid_inst <= rom_data_i;
    end
  end

  // IF/ID boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_o    <= 32'd0;
      id_inst_o  <= 32'd0;
      id_valid_o <= 1'b0;
    end else if (!stall_i) begin
      if (state == HOLD) begin
        id_pc_o    <= skid_pc;
        id_inst_o  <= skid_inst;
        id_valid_o <= 1'b1;
      end else if (ack_fire) begin
        id_pc_o    <= pc;
        id_inst_o  <= rom_data_i;
        id_valid_o <= 1'b1;
      end else begin
        id_inst_o  <= 32'd0;
        id_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: scripted ROM latency, inline checks per scenario,
// and a scoreboard pairing every accepted fetch with exactly one ID delivery.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_ack_i;
  logic [31:0] rom_data_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic        stallreq_o;

  int          checks = 0;
  int          errors = 0;

  logic        rom_en;
  logic        force_ack;
  logic [31:0] slow_addr;
  int          slow_lat;
  int          wait_cnt = 0;
  int          cur_lat;

  logic [31:0] exp_q[$];
  logic        stall_e = 1'b0;
  logic        rst_e = 1'b1;

  if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_ack_i(rom_ack_i),
    .rom_data_i(rom_data_i), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
    .id_valid_o(id_valid_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // ROM model: slow_addr gets slow_lat wait states, everything else answers at once.
  assign cur_lat    = (rom_addr_o == slow_addr) ? slow_lat : 0;
  assign rom_ack_i  = force_ack | (rom_en & rom_req_o & (wait_cnt >= cur_lat));
  assign rom_data_i = force_ack ? 32'hDEAD_BEEF : inst_of(rom_addr_o);

  always @(posedge clk) begin
    wait_cnt <= (rom_en && rom_req_o && !rom_ack_i) ? wait_cnt + 1 : 0;
    stall_e  <= stall_i;
    rst_e    <= rst;
  end

  // Scoreboard: push every accepted fetch, pop on each new ID delivery.
  always @(negedge clk) begin
    logic [31:0] a;
    if (rst_e) exp_q.delete();
    else if (!stall_e && id_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected pc=%h inst=%h required no delivery", id_pc_o, id_inst_o);
      end else begin
        a = exp_q.pop_front();
        if (id_pc_o !== a || id_inst_o !== inst_of(a)) begin
          errors++;
          $display("FAIL sb_deliver pc=%h inst=%h required pc=%h inst=%h",
                   id_pc_o, id_inst_o, a, inst_of(a));
        end
      end
    end
    if (!rst && rom_req_o && rom_ack_i) exp_q.push_back(rom_addr_o);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rom_en = 1'b0; force_ack = 1'b0; stall_i = 1'b0;
    branch_flag_i = 1'b0; branch_target_address_i = 32'd0;
    slow_addr = 32'hFFFF_FFFF; slow_lat = 0;
    cyc(); cyc();
    @(negedge clk);
    checks++;
    if (rom_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
      errors++; $display("FAIL reset_req req=%b stallreq=%b required 0 0", rom_req_o, stallreq_o);
    end
    checks++;
    if (id_valid_o !== 1'b0 || id_pc_o !== 32'd0 || id_inst_o !== 32'd0) begin
      errors++; $display("FAIL reset_id valid=%b pc=%h inst=%h required 0 0 0", id_valid_o, id_pc_o, id_inst_o);
    end
    cyc(); rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rom_req_o !== 1'b1 || rom_addr_o !== RESET_PC || stallreq_o !== 1'b1) begin
      errors++; $display("FAIL first_req req=%b addr=%h stallreq=%b required 1 %h 1", rom_req_o, rom_addr_o, stallreq_o, RESET_PC);
    end
    cyc();
  endtask

  task automatic test_zero_wait();
    rom_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rom_addr_o !== 32'(4 * i) || stallreq_o !== 1'b0) begin
        errors++; $display("FAIL zw_addr addr=%h stallreq=%b required %h 0", rom_addr_o, stallreq_o, 32'(4 * i));
      end
      if (i > 0) begin
        checks++;
        if (id_valid_o !== 1'b1 || id_pc_o !== 32'(4 * (i - 1))) begin
          errors++; $display("FAIL zw_id valid=%b pc=%h required 1 %h", id_valid_o, id_pc_o, 32'(4 * (i - 1)));
        end
      end
      cyc();
    end
    rom_en = 1'b0;
    cyc();
    @(negedge clk);
    checks++;
    if (id_valid_o !== 1'b0 || id_inst_o !== 32'd0 || id_pc_o !== 32'h0C) begin
      errors++; $display("FAIL bubble valid=%b inst=%h pc=%h required 0 0 0000000c", id_valid_o, id_inst_o, id_pc_o);
    end
    cyc();
  endtask

  task automatic test_wait_states();
    slow_addr = 32'h10; slow_lat = 2; rom_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (stallreq_o !== 1'b1 || rom_addr_o !== 32'h10 || id_valid_o !== 1'b0 || id_inst_o !== 32'd0) begin
        errors++; $display("FAIL ws_wait stallreq=%b addr=%h valid=%b inst=%h required 1 00000010 0 0",
                           stallreq_o, rom_addr_o, id_valid_o, id_inst_o);
      end
      cyc();
    end
    @(negedge clk);
    checks++;
    if (stallreq_o !== 1'b0 || rom_addr_o !== 32'h10 || id_valid_o !== 1'b0) begin
      errors++; $display("FAIL ws_ack stallreq=%b addr=%h valid=%b required 0 00000010 0", stallreq_o, rom_addr_o, id_valid_o);
    end
    cyc();
  endtask

  task automatic test_branch_same_cycle();
    branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
    @(negedge clk);
    checks++;
    if (id_pc_o !== 32'h10 || id_valid_o !== 1'b1 || rom_addr_o !== 32'h14 || rom_ack_i !== 1'b1) begin
      errors++; $display("FAIL bs_setup pc=%h valid=%b addr=%h ack=%b required 00000010 1 00000014 1",
                         id_pc_o, id_valid_o, rom_addr_o, rom_ack_i);
    end
    cyc(); branch_flag_i = 1'b0;
    @(negedge clk);
    checks++;
    if (id_pc_o !== 32'h14 || rom_addr_o !== 32'h100) begin
      errors++; $display("FAIL bs_delay pc=%h addr=%h required 00000014 00000100", id_pc_o, rom_addr_o);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (id_pc_o !== 32'h100 || rom_addr_o !== 32'h104) begin
      errors++; $display("FAIL bs_target pc=%h addr=%h required 00000100 00000104", id_pc_o, rom_addr_o);
    end
    cyc();
  endtask

  task automatic test_branch_before_ack();
    slow_addr = 32'h108; slow_lat = 1;
    branch_flag_i = 1'b1; branch_target_address_i = 32'h200;
    @(negedge clk);
    checks++;
    if (rom_addr_o !== 32'h108 || stallreq_o !== 1'b1) begin
      errors++; $display("FAIL bd_wait addr=%h stallreq=%b required 00000108 1", rom_addr_o, stallreq_o);
    end
    cyc(); branch_flag_i = 1'b0;
    @(negedge clk);
    checks++;
    if (rom_addr_o !== 32'h108 || stallreq_o !== 1'b0 || id_valid_o !== 1'b0) begin
      errors++; $display("FAIL bd_ack addr=%h stallreq=%b valid=%b required 00000108 0 0", rom_addr_o, stallreq_o, id_valid_o);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (id_pc_o !== 32'h108 || rom_addr_o !== 32'h200) begin
      errors++; $display("FAIL bd_delay pc=%h addr=%h required 00000108 00000200", id_pc_o, rom_addr_o);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (id_pc_o !== 32'h200 || rom_addr_o !== 32'h204) begin
      errors++; $display("FAIL bd_target pc=%h addr=%h required 00000200 00000204", id_pc_o, rom_addr_o);
    end
    cyc();
  endtask

  task automatic test_stall_hold();
    stall_i = 1'b1;
    @(negedge clk);
    checks++;
    if (rom_addr_o !== 32'h208 || rom_ack_i !== 1'b1 || id_pc_o !== 32'h204) begin
      errors++; $display("FAIL st_setup addr=%h ack=%b pc=%h required 00000208 1 00000204", rom_addr_o, rom_ack_i, id_pc_o);
    end
    cyc();
    for (int j = 0; j < 3; j++) begin
      if (j == 2) begin
        stall_i = 1'b0; branch_flag_i = 1'b1; branch_target_address_i = 32'hFFFF_FFFC;
      end
      @(negedge clk);
      checks++;
      if (rom_req_o !== 1'b0 || id_pc_o !== 32'h204 || id_valid_o !== 1'b1 || id_inst_o !== inst_of(32'h204)) begin
        errors++; $display("FAIL st_frozen req=%b pc=%h valid=%b inst=%h required 0 00000204 1 %h",
                           rom_req_o, id_pc_o, id_valid_o, id_inst_o, inst_of(32'h204));
      end
      cyc();
    end
    branch_flag_i = 1'b0;
    @(negedge clk);
    checks++;
    if (id_pc_o !== 32'h208 || id_valid_o !== 1'b1 || rom_req_o !== 1'b1 || rom_addr_o !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL st_release pc=%h valid=%b req=%b addr=%h required 00000208 1 1 fffffffc",
                         id_pc_o, id_valid_o, rom_req_o, rom_addr_o);
    end
    cyc();
  endtask

  task automatic test_wrap_misaligned();
    branch_flag_i = 1'b1; branch_target_address_i = 32'h103;
    @(negedge clk);
    checks++;
    if (id_pc_o !== 32'hFFFF_FFFC || rom_addr_o !== 32'h0) begin
      errors++; $display("FAIL wrap pc=%h addr=%h required fffffffc 00000000", id_pc_o, rom_addr_o);
    end
    cyc(); branch_flag_i = 1'b0;
    @(negedge clk);
    checks++;
    if (id_pc_o !== 32'h0 || rom_addr_o !== 32'h100) begin
      errors++; $display("FAIL misalign pc=%h addr=%h required 00000000 00000100", id_pc_o, rom_addr_o);
    end
    cyc();
  endtask

  task automatic test_reset_mid_fetch();
    slow_addr = 32'h104; slow_lat = 4;
    @(negedge clk);
    checks++;
    if (rom_addr_o !== 32'h104 || stallreq_o !== 1'b1) begin
      errors++; $display("FAIL rm_wait addr=%h stallreq=%b required 00000104 1", rom_addr_o, stallreq_o);
    end
    cyc(); rst = 1'b1; force_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (rom_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
      errors++; $display("FAIL rm_req req=%b stallreq=%b required 0 0", rom_req_o, stallreq_o);
    end
    cyc(); force_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (id_valid_o !== 1'b0 || id_pc_o !== 32'd0 || id_inst_o !== 32'd0) begin
      errors++; $display("FAIL rm_id valid=%b pc=%h inst=%h required 0 0 0", id_valid_o, id_pc_o, id_inst_o);
    end
    cyc(); rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rom_req_o !== 1'b1 || rom_addr_o !== RESET_PC) begin
      errors++; $display("FAIL rm_first req=%b addr=%h required 1 %h", rom_req_o, rom_addr_o, RESET_PC);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (id_valid_o !== 1'b1 || id_pc_o !== RESET_PC || id_inst_o !== inst_of(RESET_PC)) begin
      errors++; $display("FAIL rm_deliver valid=%b pc=%h inst=%h required 1 %h %h",
                         id_valid_o, id_pc_o, id_inst_o, RESET_PC, inst_of(RESET_PC));
    end
    cyc();
  endtask

  task automatic test_drain();
    slow_addr = 32'hFFFF_FFFF;
    repeat (3) cyc();
    rom_en = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch_same_cycle();
    test_branch_before_ack();
    test_stall_hold();
    test_wrap_misaligned();
    test_reset_mid_fetch();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d errors=%0d required completion", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the naive-mips 5-stage pipeline. It is the producer side of the ID interface: it generates pc and inst for the decoder and consumes the decoder's branch_flag/branch_target_address.
- Owns the PC register, a req/ack handshake to instruction memory (variable latency), and the IF/ID pipeline register with a one-entry skid buffer.
- MIPS branch-delay-slot semantics: the instruction fetched after a branch always executes.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits[1:0] must be 0.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- stall_i  in  1  pipeline-control stall for IF/ID; 1 = hold ID outputs
- branch_flag_i  in  1  ID requests a redirect
- branch_target_address_i  in  32  redirect target
- rom_req_o  out  1  fetch request valid
- rom_addr_o  out  32  fetch address (word aligned)
- rom_ack_i  in  1  memory returns data this cycle
- rom_data_i  in  32  instruction word; valid when rom_ack_i=1
- id_pc_o  out  32  pc of the instruction presented to ID
- id_inst_o  out  32  instruction presented to ID
- id_valid_o  out  1  id_inst_o is a real instruction (0 = bubble)
- stallreq_o  out  1  fetch waiting on memory; to pipeline control

Behaviour:
- Reset (rst=1 at edge) sets:
  - pc=RESET_PC
  - id_pc_o=0, id_inst_o=0, id_valid_o=0
  - skid buffer empty, redirect_pending=0
  - state=FETCH
- rom_req_o is 0 in any cycle where rst=1. The first request (addr RESET_PC) is asserted in the cycle after rst falls.
- Reset mid-request abandons the outstanding fetch. Any ack arriving during rst is ignored.
- FSM state FETCH:
  - rom_req_o=1 and rom_addr_o={pc[31:2],2'b00}.
  - Address stays stable until an edge with rom_ack_i=1.
  - Ack may arrive in the same cycle as the request, giving zero wait states and 1 instruction/cycle.
- FSM state HOLD:
  - Entered when an ack arrives while stall_i=1. rom_data_i and the fetch pc are captured into the skid buffer.
  - rom_req_o=0 while in HOLD.
  - On an edge with stall_i=0: the buffer moves to id_* with id_valid_o=1, the buffer empties, and the state returns to FETCH (the request reasserts the next cycle).
- On ack in FETCH with stall_i=0:
  - id_inst_o<=rom_data_i, id_pc_o<=pc, id_valid_o<=1.
  - pc advances to the next pc.
- Next pc selection at an ack edge:
  - redirect_pending or branch_flag_i (sampled with stall_i=0): target[31:2],00. Clears redirect_pending.
  - Otherwise: pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Branch handling:
  - branch_flag_i is honoured only on edges with stall_i=0; while stalled, ID re-presents it.
  - Branch sampled with no ack: the target is latched and redirect_pending<=1. The in-flight fetch completes and is delivered as the delay slot; the next request uses the target.
  - Branch and ack in the same cycle: the acked word is the delay slot, and the next pc is the target.
  - A second branch while one is pending overwrites the latched target.
  - A branch that arrives while the state is HOLD is latched the same way and applies to the fetch after the buffered instruction.
- When stall_i=0 and no instruction is delivered this edge, id_valid_o<=0 and id_inst_o<=0 (NOP bubble); id_pc_o holds.
- When stall_i=1, all id_* outputs hold.
- Target bits[1:0] are ignored (forced to 00); no address-error exception is raised here.
- stallreq_o = rom_req_o & ~rom_ack_i (combinational).
- No instruction is ever dropped or duplicated. Data accepted from ack is always delivered exactly once.

Test Plan:
- Reset, then a zero-wait ROM (ack tied to req): rom_addr_o runs 0,4,8,C on consecutive cycles. The ID side sees the pc sequence 0,4,8 with id_valid_o=1 one cycle after each ack. stallreq_o stays 0.
- ROM with 2 wait states at addr 0x4: stallreq_o=1 for 2 cycles, rom_addr_o holds 0x4, and ID gets 2 bubbles (valid=0, inst=0) before pc 0x4.
- With id_pc_o=0x10, pulse branch_flag_i with target 0x100 in the same cycle as the ack of 0x14: ID receives 0x14 (delay slot) and then 0x100, with 0x18 never requested. Repeat with the branch arriving 1 cycle before a delayed ack: same ordering.
- Hold stall_i=1 for 3 cycles while the ack for 0x20 arrives: rom_req_o drops and id_* stay frozen. When stall_i falls, ID gets 0x20 and the next request is 0x24. No duplicate or loss.
- Assert rst during a wait-stated fetch, with a stray ack during reset: all outputs reset. The first post-reset request is RESET_PC and the stray data never reaches ID.
- Redirect to 0xFFFF_FFFC: the next sequential fetch after it is 0x0000_0000. A misaligned target 0x103 fetches 0x100.
